// File: rtl/imem_fetch_port.sv
// imem_fetch_port: handshaked instruction memory for the fetch stage.
// Synchronous-read word store, in-order response FIFO of depth READ_LATENCY+1,
// flush for branch redirects, fault reporting and a runtime program port.
module imem_fetch_port #(
  parameter int unsigned           ADDR_WIDTH   = 10,
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter int unsigned           READ_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD     = 32'hE1A00000,
  parameter string                 INIT_FILE    = ""
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_addr,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_instr,
  output logic                  resp_fault,
  input  logic                  flush,
  input  logic                  prog_we,
  input  logic [ADDR_WIDTH-1:0] prog_addr,
  input  logic [DATA_WIDTH-1:0] prog_data
);

  localparam int unsigned     DEPTH     = 2 ** ADDR_WIDTH;
  localparam int unsigned     FD        = READ_LATENCY + 1;
  localparam int unsigned     PW        = $clog2(FD);
  localparam int unsigned     OW        = $clog2(FD + 1);
  localparam logic [OW-1:0]   OCC_MAX   = OW'(FD);
  localparam logic [PW-1:0]   PTR_LAST  = PW'(FD - 1);
  localparam logic            WAIT_INIT = (READ_LATENCY == 2);

  if ((READ_LATENCY != 1) && (READ_LATENCY != 2)) begin : g_bad_latency
    $error("imem_fetch_port: READ_LATENCY must be 1 or 2");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [DATA_WIDTH-1:0] slot_data_q [FD];
  logic [FD-1:0]         slot_fault_q;
  logic [FD-1:0]         slot_wait_q;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         fill_slot_q;
  logic                  fill_v_q;
  logic [OW-1:0]         occ_q, occ_d;
  logic [DATA_WIDTH-1:0] last_instr_q, last_instr_d;
  logic                  last_fault_q, last_fault_d;

  logic [ADDR_WIDTH-1:0] rd_idx;
  logic                  req_fault;
  logic                  accept;
  logic                  pop;
  logic                  head_vis;
  logic [DATA_WIDTH-1:0] head_raw;
  logic [DATA_WIDTH-1:0] head_instr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Memory image at elaboration: all NOP_WORD.
  initial begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mem_q[i] = NOP_WORD;
    end
  end

  // Handshake, fault decode, FIFO head selection and next-state pointers.
  always_comb begin
    rd_idx     = req_addr[ADDR_WIDTH+1:2];
    req_fault  = (|req_addr[1:0]) | (|req_addr[31:ADDR_WIDTH+2]);
    req_ready  = !rst && !flush && !prog_we && (occ_q < OCC_MAX);
    accept     = req_valid && req_ready;

    // An entry is visible once its read has landed; the newest read may
    // still sit in rd_data_q for one cycle before it is copied to its slot.
    head_vis   = (occ_q != '0) && !slot_wait_q[rd_ptr_q];
    head_raw   = (fill_v_q && (fill_slot_q == rd_ptr_q)) ? rd_data_q
                                                         : slot_data_q[rd_ptr_q];
    head_instr = slot_fault_q[rd_ptr_q] ? NOP_WORD : head_raw;
    pop        = head_vis && resp_ready;

    resp_valid = head_vis;
    resp_instr = head_vis ? head_instr : last_instr_q;
    resp_fault = head_vis ? slot_fault_q[rd_ptr_q] : last_fault_q;
    last_instr_d = resp_instr;
    last_fault_d = resp_fault;

    wr_ptr_d = accept ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    occ_d    = occ_q;
    if (accept && !pop) begin
      occ_d = occ_q + 1'b1;
    end else if (!accept && pop) begin
      occ_d = occ_q - 1'b1;
    end

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end
  end

  // Storage: program-port write and synchronous read captured at acceptance.
  always_ff @(posedge clk) begin
    if (prog_we && !rst) begin
      mem_q[prog_addr] <= prog_data;
    end
    if (accept) begin
      rd_data_q <= mem_q[rd_idx];
    end
  end

  // FIFO payload: fault flag written at acceptance, data one edge later.
  always_ff @(posedge clk) begin
    if (fill_v_q) begin
      slot_data_q[fill_slot_q] <= rd_data_q;
    end
    if (accept) begin
      slot_fault_q[wr_ptr_q] <= req_fault;
    end
  end

  // Extra-latency marker: a new entry waits exactly one edge when READ_LATENCY is 2.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_wait_q <= '0;
    end else begin
      slot_wait_q <= '0;
      if (accept) begin
        slot_wait_q[wr_ptr_q] <= WAIT_INIT;
      end
    end
  end

  // Control state: pointers, occupancy, pending fill and held output values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
      fill_v_q     <= 1'b0;
      fill_slot_q  <= '0;
      last_instr_q <= NOP_WORD;
      last_fault_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      occ_q        <= occ_d;
      fill_v_q     <= accept;
      fill_slot_q  <= wr_ptr_q;
      last_instr_q <= last_instr_d;
      last_fault_q <= last_fault_d;
    end
  end

endmodule

// File: tb/tb_imem_fetch_port.sv
// Testbench for imem_fetch_port: two instances (READ_LATENCY 1 and 2) share one
// stimulus stream; each is compared every cycle against a transaction-level model.
module tb_imem_fetch_port;

    localparam logic [31:0] NOP = 32'hE1A00000;

    logic        clk = 1'b0;
    logic        rst, req_valid, resp_ready, flush, prog_we;
    logic [31:0] req_addr, prog_data;
    logic [9:0]  prog_addr;
    logic [1:0]  rr, rv, rf;
    logic [31:0] ri0, ri1;

    always #5 clk = ~clk;

    imem_fetch_port #(
        .ADDR_WIDTH(10), .DATA_WIDTH(32), .READ_LATENCY(1), .NOP_WORD(NOP), .INIT_FILE("")
    ) u_lat1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rr[0]), .req_addr(req_addr),
        .resp_valid(rv[0]), .resp_ready(resp_ready), .resp_instr(ri0), .resp_fault(rf[0]),
        .flush(flush), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
    );

    imem_fetch_port #(
        .ADDR_WIDTH(10), .DATA_WIDTH(32), .READ_LATENCY(2), .NOP_WORD(NOP), .INIT_FILE("")
    ) u_lat2 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rr[1]), .req_addr(req_addr),
        .resp_valid(rv[1]), .resp_ready(resp_ready), .resp_instr(ri1), .resp_fault(rf[1]),
        .flush(flush), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit checking = 1'b0;

    // Reference model: per latency, an ordered list of outstanding responses,
    // each tagged with the cycle in which it becomes visible.
    int          due  [2][8];
    logic [31:0] mdat [2][8];
    logic        mflt [2][8];
    int          cnt  [2];
    logic [31:0] last_i [2];
    logic        last_f [2];
    logic [31:0] mmem [1024];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h at cycle %0d", tag, obs, exp_v, cyc);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            int          lat;
            logic        vis;
            logic        e_rdy;
            logic [31:0] e_i;
            logic        e_f;
            logic [31:0] o_i;
            lat   = k + 1;
            vis   = (cnt[k] > 0) && (due[k][0] <= cyc);
            e_rdy = !rst && !flush && !prog_we && (cnt[k] < lat + 1);
            e_i   = vis ? mdat[k][0] : last_i[k];
            e_f   = vis ? mflt[k][0] : last_f[k];
            o_i   = (k == 0) ? ri0 : ri1;
            chk($sformatf("lat%0d_req_ready", lat), {31'b0, rr[k]}, {31'b0, e_rdy});
            chk($sformatf("lat%0d_resp_valid", lat), {31'b0, rv[k]}, {31'b0, vis});
            chk($sformatf("lat%0d_resp_instr", lat), o_i, e_i);
            chk($sformatf("lat%0d_resp_fault", lat), {31'b0, rf[k]}, {31'b0, e_f});
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            int   lat;
            logic vis;
            logic acc;
            logic flt;
            lat = k + 1;
            vis = (cnt[k] > 0) && (due[k][0] <= cyc);
            if (vis) begin
                last_i[k] = mdat[k][0];
                last_f[k] = mflt[k][0];
            end
            if (rst) begin
                cnt[k]    = 0;
                last_i[k] = NOP;
                last_f[k] = 1'b0;
            end else begin
                acc = req_valid && !flush && !prog_we && (cnt[k] < lat + 1);
                if (vis && resp_ready) begin
                    for (int j = 0; j < 7; j++) begin
                        due[k][j]  = due[k][j+1];
                        mdat[k][j] = mdat[k][j+1];
                        mflt[k][j] = mflt[k][j+1];
                    end
                    cnt[k]--;
                end
                if (acc) begin
                    flt = (req_addr[1:0] != 2'b00) || (req_addr[31:12] != 20'h0);
                    due[k][cnt[k]]  = cyc + lat;
                    mflt[k][cnt[k]] = flt;
                    mdat[k][cnt[k]] = flt ? NOP : mmem[req_addr[11:2]];
                    cnt[k]++;
                end
                if (flush) cnt[k] = 0;
            end
        end
        if (prog_we && !rst) mmem[prog_addr] = prog_data;
        cyc++;
    endtask

    task automatic tick();
        #1;
        if (checking) check_all();
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rst = 1'b0; req_valid = 1'b0; req_addr = '0; resp_ready = 1'b1;
        flush = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    endtask

    task automatic fetch(input logic [31:0] a);
        req_valid = 1'b1; req_addr = a;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic prog(input int w, input logic [31:0] d);
        prog_we = 1'b1; prog_addr = w[9:0]; prog_data = d;
        tick();
        prog_we = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mmem[i] = NOP;
        for (int k = 0; k < 2; k++) begin
            cnt[k] = 0; last_i[k] = NOP; last_f[k] = 1'b0;
        end

        // reset, then observe reset state
        idle_inputs();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        checking = 1'b1;
        idle(2);

        // preload program (word 5 gets an "old" value for the write-while-reading case)
        prog(0, 32'hE3A01005);
        prog(1, 32'hE3A02003);
        prog(2, 32'hE0813002);
        prog(3, 32'hE0434001);
        prog(5, 32'h11111111);
        idle(1);

        // basic back-to-back fetch
        fetch(32'h0); fetch(32'h4); fetch(32'h8); fetch(32'hC);
        idle(4);

        // faults followed by a good fetch
        fetch(32'h6); fetch(32'h1000); fetch(32'h0);
        idle(4);

        // back-pressure: five requests with no consumer, hold, then drain
        resp_ready = 1'b0;
        fetch(32'h0); fetch(32'h4); fetch(32'h8); fetch(32'hC); fetch(32'h14);
        idle(3);
        resp_ready = 1'b1;
        idle(5);

        // flush one cycle before the first response of the longer pipeline
        fetch(32'h0);
        flush = 1'b1; fetch(32'h4); flush = 1'b0;
        fetch(32'hC);
        flush = 1'b1; tick(); flush = 1'b0;
        idle(2);
        fetch(32'h8);
        idle(4);

        // program write while a read of the same word is in flight
        fetch(32'h14);
        prog_we = 1'b1; prog_addr = 10'd5; prog_data = 32'hEAFFFFFE;
        fetch(32'h14);
        prog_we = 1'b0;
        fetch(32'h14);
        idle(4);

        // reset with responses buffered
        resp_ready = 1'b0;
        fetch(32'h0); fetch(32'h4);
        idle(2);
        rst = 1'b1; prog_we = 1'b1; prog_addr = 10'd0; prog_data = 32'hDEADBEEF;
        tick();
        rst = 1'b0; prog_we = 1'b0;
        idle(3);
        resp_ready = 1'b1;
        fetch(32'h0); fetch(32'h14);
        idle(4);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            int r;
            req_valid  = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 15);
            if (r == 0)      req_addr = $urandom;
            else if (r == 1) req_addr = ($urandom_range(0, 15) << 2) | $urandom_range(1, 3);
            else             req_addr = $urandom_range(0, 15) << 2;
            resp_ready = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 29) == 0);
            prog_we    = ($urandom_range(0, 19) == 0);
            prog_addr  = 10'($urandom_range(0, 15));
            prog_data  = $urandom;
            rst        = ($urandom_range(0, 99) == 0);
            tick();
        end
        idle_inputs();
        idle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
